// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier.
//   state_e     : sequencer states (IDLE, RUN)
//   digit_e     : recoded Booth digit (0, +A, +2A, -A, -2A)
//   calc_ew     : extended operand width (even, with one spare extension bit)
//   calc_iter   : number of Booth steps for a given operand width
//   booth_digit : 3-bit multiplier window -> Booth digit
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } digit_e;

    // Even width that also leaves room for a zero/sign extension bit.
    function automatic int unsigned calc_ew(input int unsigned width);
        return ((width % 2) == 0) ? (width + 2) : (width + 1);
    endfunction

    function automatic int unsigned calc_iter(input int unsigned width);
        return calc_ew(width) / 2;
    endfunction

    // Window is {b[2i+1], b[2i], b[2i-1]}.
    function automatic digit_e booth_digit(input logic [2:0] win);
        digit_e d;
        case (win)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth partial-product generator (purely combinational).
//   win  : 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
//   a    : EW-bit two's-complement multiplicand
//   pp_c : EW+1-bit signed partial product in {0, +/-A, +/-2A}
module booth_r4_enc #(
    parameter int unsigned EW = 34
) (
    input  logic [2:0]  win,
    input  logic [EW-1:0] a,
    output logic [EW:0]   pp_c
);
    import booth_pkg::*;

    localparam int unsigned PW = EW + 1;

    logic [EW:0] a1;
    logic [EW:0] a2;
    digit_e      digit;

    // One extra bit is enough to hold 2A and its negation without overflow.
    always_comb begin
        a1    = {a[EW-1], a};
        a2    = {a, 1'b0};
        digit = booth_digit(win);
        pp_c  = '0;
        case (digit)
            POS1:    pp_c = a1;
            POS2:    pp_c = a2;
            NEG1:    pp_c = (~a1) + PW'(1);
            NEG2:    pp_c = (~a2) + PW'(1);
            default: pp_c = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier, two multiplier bits retired per cycle.
//   CLK, RST      : clock, asynchronous active-high reset
//   start         : request, sampled only while idle
//   is_signed     : 1 = two's-complement operands, sampled with start
//   in_a, in_b    : multiplicand / multiplier, sampled with start
//   busy          : high while an operation is in flight
//   product       : last completed result (held until the next completion)
//   product_valid : one-cycle completion pulse
module booth_mult_r4 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               busy,
    output logic [2*WIDTH-1:0] product,
    output logic               product_valid
);
    import booth_pkg::*;

    localparam int unsigned EW   = calc_ew(WIDTH);
    localparam int unsigned ITER = calc_iter(WIDTH);
    localparam int unsigned XW   = EW - WIDTH;
    localparam int unsigned AW   = 2 * EW;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned SXW  = AW - EW - 1;
    localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned SW   = CW + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(ITER - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [EW-1:0]   a_q, a_d;
    logic [EW:0]     b_q, b_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [PW-1:0]   product_q, product_d;

    logic [EW-1:0]   a_ext;
    logic [EW-1:0]   b_ext;
    logic [EW:0]     pp_c;
    logic [AW-1:0]   pp_ext;
    logic [SW-1:0]   shamt;
    logic [AW-1:0]   pp_shifted;

    // Multiplier is shifted right each step, so the window is always b_q[2:0].
    booth_r4_enc #(
        .EW (EW)
    ) u_enc (
        .win  (b_q[2:0]),
        .a    (a_q),
        .pp_c (pp_c)
    );

    // Operand extension to EW bits: sign bit for signed, zero for unsigned.
    always_comb begin
        a_ext = is_signed ? {{XW{in_a[WIDTH-1]}}, in_a} : {{XW{1'b0}}, in_a};
        b_ext = is_signed ? {{XW{in_b[WIDTH-1]}}, in_b} : {{XW{1'b0}}, in_b};
    end

    // Partial product weighted by 4^step.
    always_comb begin
        pp_ext     = {{SXW{pp_c[EW]}}, pp_c};
        shamt      = {cnt_q, 1'b0};
        pp_shifted = pp_ext << shamt;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a_ext;
                    b_d     = {b_ext, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                acc_d = acc_q + pp_shifted;
                b_d   = {2'b00, b_q[EW:2]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    busy_d    = 1'b0;
                    valid_d   = 1'b1;
                    product_d = acc_d[PW-1:0];
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            product_q <= product_d;
        end
    end

    assign busy          = busy_q;
    assign product       = product_q;
    assign product_valid = valid_q;

endmodule

// File: tb/tb_booth_mult_r4.sv
// Self-checking bench for booth_mult_r4 at WIDTH = 32, 16 and 7.
module tb_booth_mult_r4;

    logic CLK;
    logic RST;

    logic        st32, sg32, busy32, v32;
    logic [31:0] a32, b32;
    logic [63:0] p32;

    logic        st16, sg16, busy16, v16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    logic        st7, sg7, busy7, v7;
    logic [6:0]  a7, b7;
    logic [13:0] p7;

    int checks;
    int errors;

    booth_mult_r4 #(.WIDTH(32)) u32 (
        .CLK(CLK), .RST(RST), .start(st32), .is_signed(sg32),
        .in_a(a32), .in_b(b32), .busy(busy32), .product(p32), .product_valid(v32)
    );
    booth_mult_r4 #(.WIDTH(16)) u16 (
        .CLK(CLK), .RST(RST), .start(st16), .is_signed(sg16),
        .in_a(a16), .in_b(b16), .busy(busy16), .product(p16), .product_valid(v16)
    );
    booth_mult_r4 #(.WIDTH(7)) u7 (
        .CLK(CLK), .RST(RST), .start(st7), .is_signed(sg7),
        .in_a(a7), .in_b(b7), .busy(busy7), .product(p7), .product_valid(v7)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    function automatic logic [31:0] opmask(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return m;
    endfunction

    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic s);
        longint av, bv;
        logic [63:0] p, m;
        av = longint'({32'd0, a & opmask(w)});
        bv = longint'({32'd0, b & opmask(w)});
        if (s) begin
            av = (av <<< (64 - w)) >>> (64 - w);
            bv = (bv <<< (64 - w)) >>> (64 - w);
        end
        p = 64'(av * bv);
        m = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        return p & m;
    endfunction

    function automatic int exp_lat(input int w);
        return w / 2 + 1;
    endfunction

    // ---------------- DUT access ----------------
    function automatic logic get_valid(input int w);
        return (w == 32) ? v32 : (w == 16) ? v16 : v7;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 32) ? busy32 : (w == 16) ? busy16 : busy7;
    endfunction

    function automatic logic [63:0] get_prod(input int w);
        return (w == 32) ? p32 : (w == 16) ? 64'(p16) : 64'(p7);
    endfunction

    task automatic drive(input int w, input logic st, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
        case (w)
            32: begin st32 = st; a32 = a; b32 = b; sg32 = s; end
            16: begin st16 = st; a16 = a[15:0]; b16 = b[15:0]; sg16 = s; end
            default: begin st7 = st; a7 = a[6:0]; b7 = b[6:0]; sg7 = s; end
        endcase
    endtask

    // Counts negedges until product_valid; lat 0 is the negedge right after the start edge.
    task automatic wait_valid(input int w, output logic [63:0] p, output int lat, output int bhi);
        lat = 0;
        bhi = 0;
        while (!get_valid(w) && lat < 100) begin
            if (get_busy(w)) bhi++;
            @(negedge CLK);
            lat++;
        end
        p = get_prod(w);
    endtask

    // Issue one op, scramble the operand inputs after the start edge, wait for the result.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic s, output logic [63:0] p, output int lat, output int bhi);
        @(negedge CLK);
        drive(w, 1'b1, a, b, s);
        @(negedge CLK);
        drive(w, 1'b0, $urandom, $urandom, ~s);
        wait_valid(w, p, lat, bhi);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int ws[3] = '{32, 16, 7};
        RST = 1'b1;
        drive(32, 1'b0, 0, 0, 1'b0);
        drive(16, 1'b0, 0, 0, 1'b0);
        drive(7,  1'b0, 0, 0, 1'b0);
        repeat (2) @(negedge CLK);
        foreach (ws[i]) begin
            checks++;
            if (get_busy(ws[i]) !== 1'b0 || get_valid(ws[i]) !== 1'b0 || get_prod(ws[i]) !== 64'd0) begin
                errors++;
                $display("FAIL reset w=%0d busy=%b valid=%b product=%h expected 0/0/0",
                         ws[i], get_busy(ws[i]), get_valid(ws[i]), get_prod(ws[i]));
            end
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic();
        logic [63:0] p;
        int lat, bhi;
        run_op(32, 32'd3, 32'd5, 1'b0, p, lat, bhi);
        checks++;
        if (p !== 64'd15) begin errors++; $display("FAIL basic_3x5 product=%h expected %h", p, 64'd15); end
        checks++;
        if (lat !== 17) begin errors++; $display("FAIL basic_latency got=%0d expected 17", lat); end
        checks++;
        if (bhi !== 17) begin errors++; $display("FAIL basic_busy_cycles got=%0d expected 17", bhi); end
        checks++;
        if (busy32 !== 1'b0) begin errors++; $display("FAIL basic_busy_at_valid got=%b expected 0", busy32); end
        @(negedge CLK);
        checks++;
        if (v32 !== 1'b0 || p32 !== 64'd15) begin
            errors++;
            $display("FAIL basic_pulse_hold valid=%b product=%h expected 0/%h", v32, p32, 64'd15);
        end
    endtask

    task automatic test_corners();
        logic [31:0] ta[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0};
        logic [31:0] tb[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h0};
        logic        ts[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [63:0] te[5] = '{64'hFFFF_FFFE_0000_0001, 64'h1, 64'h4000_0000_0000_0000,
                               64'hFFFF_FFFF_8000_0000, 64'h0};
        logic [63:0] p;
        int lat, bhi;
        foreach (ta[i]) begin
            run_op(32, ta[i], tb[i], ts[i], p, lat, bhi);
            checks++;
            if (p !== te[i] || lat !== 17) begin
                errors++;
                $display("FAIL corner%0d a=%h b=%h s=%b product=%h lat=%0d expected %h lat=17",
                         i, ta[i], tb[i], ts[i], p, lat, te[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] p;
        int lat, bhi;
        @(negedge CLK);
        drive(32, 1'b1, 32'd7, 32'd6, 1'b0);
        @(negedge CLK);
        drive(32, 1'b0, 32'd7, 32'd6, 1'b0);
        repeat (4) @(negedge CLK);
        drive(32, 1'b1, 32'd100, 32'd200, 1'b1);
        @(negedge CLK);
        drive(32, 1'b0, 32'd55, 32'd66, 1'b0);
        wait_valid(32, p, lat, bhi);
        checks++;
        if (p !== 64'd42) begin errors++; $display("FAIL ignored_start product=%h expected %h", p, 64'd42); end
        // Start in the valid cycle.
        drive(32, 1'b1, 32'd2, 32'd9, 1'b0);
        @(negedge CLK);
        drive(32, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_valid(32, p, lat, bhi);
        checks++;
        if (p !== 64'd18 || lat !== 17) begin
            errors++;
            $display("FAIL back_to_back product=%h lat=%0d expected %h lat=17", p, lat, 64'd18);
        end
    endtask

    task automatic test_abort();
        logic [63:0] p;
        int lat, bhi, saw;
        @(negedge CLK);
        drive(32, 1'b1, 32'd11, 32'd13, 1'b0);
        @(negedge CLK);
        drive(32, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (8) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        checks++;
        if (busy32 !== 1'b0 || v32 !== 1'b0 || p32 !== 64'd0) begin
            errors++;
            $display("FAIL abort_async busy=%b valid=%b product=%h expected 0/0/0", busy32, v32, p32);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        saw = 0;
        repeat (25) begin
            @(negedge CLK);
            if (v32 || busy32) saw++;
        end
        checks++;
        if (saw !== 0) begin errors++; $display("FAIL abort_no_valid activity_cycles=%0d expected 0", saw); end
        run_op(32, 32'd123, 32'd456, 1'b0, p, lat, bhi);
        checks++;
        if (p !== 64'd56088 || lat !== 17) begin
            errors++;
            $display("FAIL abort_recover product=%h lat=%0d expected %h lat=17", p, lat, 64'd56088);
        end
    endtask

    task automatic test_width7();
        logic [63:0] p;
        int lat, bhi;
        run_op(7, 32'h40, 32'h40, 1'b1, p, lat, bhi);
        checks++;
        if (p !== 64'h1000 || lat !== 4) begin
            errors++;
            $display("FAIL w7_signed_min product=%h lat=%0d expected %h lat=4", p, lat, 64'h1000);
        end
        run_op(7, 32'h7F, 32'h7F, 1'b0, p, lat, bhi);
        checks++;
        if (p !== 64'd16129 || lat !== 4) begin
            errors++;
            $display("FAIL w7_unsigned_max product=%h lat=%0d expected %h lat=4", p, lat, 64'd16129);
        end
    endtask

    task automatic test_sweep();
        int ws[3] = '{7, 16, 32};
        logic [31:0] a, b, m;
        logic s;
        logic [63:0] p, e;
        int lat, bhi;
        foreach (ws[k]) begin
            m = opmask(ws[k]);
            for (int n = 0; n < 30; n++) begin
                case (n)
                    0: a = m;
                    1: a = (m >> 1) + 32'd1;
                    2: a = 32'd0;
                    default: a = $urandom;
                endcase
                b = (n < 3) ? ((n == 2) ? m : a) : $urandom;
                a = a & m;
                b = b & m;
                s = 1'($urandom_range(0, 1));
                e = ref_mul(ws[k], a, b, s);
                run_op(ws[k], a, b, s, p, lat, bhi);
                checks++;
                if (p !== e || lat !== exp_lat(ws[k])) begin
                    errors++;
                    $display("FAIL sweep w=%0d a=%h b=%h s=%b product=%h lat=%0d expected %h lat=%0d",
                             ws[k], a, b, s, p, lat, e, exp_lat(ws[k]));
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_abort();
        test_width7();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
